rvc_fetch_aligner: RTL

Buffered successor to the combinational RVC expander: sits between instruction memory and the decode stage, accepts word-aligned 32-bit fetch words, and splits them into 16-bit parcels in a parametrised queue. It realigns 32-bit instructions that straddle word boundaries and expands every RV32C instruction to its 32-bit equivalent. It emits one instruction per cycle with its PC over a valid/ready handshake. Redirects (branch, jump, trap) flush it, including to halfword-aligned targets.

---
 rtl/rvc_fetch_aligner.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/rvc_fetch_aligner.sv
// Fetch-side parcel queue: splits 32-bit fetch words into halfwords, realigns
// straddling 32-bit instructions and expands RV32C encodings for decode.
module rvc_fetch_aligner #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_is_comp,
  output logic        out_illegal
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [15:0]   queue [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          drop;
  logic [31:0]   pc;

  logic [15:0]   p0, p1;
  logic          is32;
  logic          push, pop;
  logic [CW-1:0] push_n, pop_n;
  logic [31:0]   exp_inst;
  logic          exp_ill;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign p0   = queue[head];
  assign p1   = queue[inc(head)];
  assign is32 = (p0[1:0] == 2'b11);

  assign fetch_ready = !redirect && (count <= CW'(DEPTH - 2));
  assign out_valid   = !redirect && (is32 ? (count >= CW'(2)) : (count != '0));

  assign push   = fetch_valid && fetch_ready;
  assign pop    = out_valid && out_ready;
  assign push_n = push ? (drop ? CW'(1) : CW'(2)) : '0;
  assign pop_n  = pop ? (is32 ? CW'(2) : CW'(1)) : '0;

  assign out_inst    = is32 ? {p1, p0} : exp_inst;
  assign out_pc      = pc;
  assign out_is_comp = !is32;
  assign out_illegal = !is32 && exp_ill;

  // Parcel storage carries no reset; validity is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push) begin
      if (drop) begin
        queue[tail] <= fetch_data[31:16];
      end else begin
        queue[tail]      <= fetch_data[15:0];
        queue[inc(tail)] <= fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drop  <= RESET_PC[1];
      pc    <= RESET_PC;
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drop  <= redirect_pc[1];
      pc    <= redirect_pc & ~32'h1;
    end else begin
      if (push) begin
        tail <= drop ? inc(tail) : inc(inc(tail));
        drop <= 1'b0;
      end
      if (pop) begin
        head <= is32 ? inc(inc(head)) : inc(head);
        pc   <= pc + (is32 ? 32'd4 : 32'd2);
      end
      count <= count + push_n - pop_n;
    end
  end

  // RV32C expansion of the head parcel; illegal encodings return the raw parcel.
  always_comb begin
    logic [4:0]  rd, rs2, rdp, rs1p;
    logic [11:0] imm6;
    logic [11:0] jimm;
    exp_inst = 32'h0;
    exp_ill  = 1'b0;
    rd   = p0[11:7];
    rs2  = p0[6:2];
    rdp  = {2'b01, p0[4:2]};
    rs1p = {2'b01, p0[9:7]};
    imm6 = {{6{p0[12]}}, p0[12], p0[6:2]};
    jimm = {p0[12], p0[8], p0[10:9], p0[6], p0[7], p0[2], p0[11], p0[5:3], 1'b0};
    case (p0[1:0])
      2'b00: begin
        case (p0[15:13])
          3'b000: begin
            exp_inst = {2'b00, p0[10:7], p0[12:11], p0[5], p0[6], 2'b00, 5'd2, 3'b000, rdp, OP_IMM};
            exp_ill  = (p0[12:5] == 8'h00);
          end
          3'b010: exp_inst = {5'b0, p0[5], p0[12:10], p0[6], 2'b00, rs1p, 3'b010, rdp, OP_LOAD};
          3'b110: exp_inst = {5'b0, p0[5], p0[12], rdp, rs1p, 3'b010, p0[11:10], p0[6], 2'b00, OP_STORE};
          default: exp_ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (p0[15:13])
          3'b000: exp_inst = {imm6, rd, 3'b000, rd, OP_IMM};
          3'b001, 3'b101:
            exp_inst = {jimm[11], jimm[10:1], jimm[11], {8{jimm[11]}},
                        (p0[15] ? 5'd0 : 5'd1), OP_JAL};
          3'b010: exp_inst = {imm6, 5'd0, 3'b000, rd, OP_IMM};
          3'b011: begin
            exp_ill = ({p0[12], p0[6:2]} == 6'h00);
            if (rd == 5'd2) begin
              exp_inst = {{3{p0[12]}}, p0[4:3], p0[5], p0[2], p0[6], 4'b0000,
                          5'd2, 3'b000, 5'd2, OP_IMM};
            end else begin
              exp_inst = {{15{p0[12]}}, p0[6:2], rd, OP_LUI};
            end
          end
          3'b100: begin
            case (p0[11:10])
              2'b00: begin
                exp_inst = {7'b0000000, p0[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                exp_ill  = p0[12];
              end
              2'b01: begin
                exp_inst = {7'b0100000, p0[6:2], rs1p, 3'b101, rs1p, OP_IMM};
                exp_ill  = p0[12];
              end
              2'b10: exp_inst = {imm6, rs1p, 3'b111, rs1p, OP_IMM};
              default: begin
                exp_ill = p0[12];
                case (p0[6:5])
                  2'b00:   exp_inst = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OP_REG};
                  2'b01:   exp_inst = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OP_REG};
                  2'b10:   exp_inst = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OP_REG};
                  default: exp_inst = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OP_REG};
                endcase
              end
            endcase
          end
          default:
            exp_inst = {p0[12], {3{p0[12]}}, p0[6:5], p0[2], 5'd0, rs1p,
                        {2'b00, p0[13]}, p0[11:10], p0[4:3], p0[12], OP_BRANCH};
        endcase
      end
      2'b10: begin
        case (p0[15:13])
          3'b000: begin
            exp_inst = {7'b0000000, p0[6:2], rd, 3'b001, rd, OP_IMM};
            exp_ill  = p0[12];
          end
          3'b010: begin
            exp_inst = {4'b0000, p0[3:2], p0[12], p0[6:4], 2'b00, 5'd2, 3'b010, rd, OP_LOAD};
            exp_ill  = (rd == 5'd0);
          end
          3'b100: begin
            if (!p0[12]) begin
              if (rs2 == 5'd0) begin
                exp_inst = {12'h000, rd, 3'b000, 5'd0, OP_JALR};
                exp_ill  = (rd == 5'd0);
              end else begin
                exp_inst = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_REG};
              end
            end else if (rs2 == 5'd0) begin
              exp_inst = (rd == 5'd0) ? 32'h0010_0073
                                      : {12'h000, rd, 3'b000, 5'd1, OP_JALR};
            end else begin
              exp_inst = {7'b0000000, rs2, rd, 3'b000, rd, OP_REG};
            end
          end
          3'b110: exp_inst = {4'b0000, p0[8:7], p0[12], rs2, 5'd2, 3'b010, p0[11:9], 2'b00, OP_STORE};
          default: exp_ill = 1'b1;
        endcase
      end
      default: exp_ill = 1'b0;
    endcase
    if (exp_ill) exp_inst = {16'h0000, p0};
  end

endmodule
